// File: rtl/nbldpc_dup_buffer_if.sv
// Candidate-stream handshake bundle for nbldpc_dup_buffer.
// Carries the input beat channel and the unique-entry output channel.
interface nbldpc_dup_buffer_if #(
   parameter int Q_W   = 7,
   parameter int LLR_W = 6
) ();
   logic             in_valid;
   logic             in_ready;
   logic [Q_W-1:0]   in_q;
   logic [LLR_W-1:0] in_llr;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [Q_W-1:0]   out_q;
   logic [LLR_W-1:0] out_llr;
   logic             out_last;

   modport master (
      output in_valid, in_q, in_llr, in_last, out_ready,
      input  in_ready, out_valid, out_q, out_llr, out_last
   );

   modport slave (
      input  in_valid, in_q, in_llr, in_last, out_ready,
      output in_ready, out_valid, out_q, out_llr, out_last
   );
endinterface

// File: rtl/nbldpc_dup_buffer.sv
// Duplicate-suppressing (Q, LLR) candidate buffer: collect a set, then flush.
// Optional NBLDPC_DUP_MAXLLR_EN: a duplicate raises the stored LLR if larger.
module nbldpc_dup_buffer #(
   parameter int Q_W   = 7,
   parameter int LLR_W = 6,
   parameter int DEPTH = 32,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   nbldpc_dup_buffer_if.slave bus,
   output logic [CNT_W-1:0] count,
   output logic             dup_drop,
   output logic             overflow
);

   typedef enum logic {COLLECT, FLUSH} state_t;

   state_t           state;
   state_t           state_nx;
   logic [Q_W-1:0]   q_mem   [DEPTH];
   logic [LLR_W-1:0] llr_mem [DEPTH];
   logic [CNT_W-1:0] rd_ptr;
   logic [DEPTH-1:0] hit_vec;
   logic             accept;
   logic             hit;
   logic             full;
   logic             do_store;
   logic             pop;
   logic             pop_last;
   logic             end_set;
   logic [Q_W-1:0]   rd_q;
   logic [LLR_W-1:0] rd_llr;

   assign accept   = bus.in_valid & bus.in_ready;
   assign hit      = |hit_vec;
   assign full     = (count == CNT_W'(DEPTH));
   assign do_store = accept & ~hit & ~full;
   assign end_set  = accept & bus.in_last;
   assign pop      = bus.out_valid & bus.out_ready;
   assign pop_last = pop & bus.out_last;

   // Parallel compare against occupied slots only; stale slots never match.
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i] = (CNT_W'(i) < count) && (q_mem[i] == bus.in_q);
      end
   end

   // Read mux for the entry at the flush pointer.
   always_comb begin
      rd_q   = '0;
      rd_llr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_ptr == CNT_W'(i)) begin
            rd_q   = q_mem[i];
            rd_llr = llr_mem[i];
         end
      end
   end

   // Output channel is zero outside FLUSH so idle outputs are quiet.
   always_comb begin
      bus.out_q    = (state == FLUSH) ? rd_q : '0;
      bus.out_llr  = (state == FLUSH) ? rd_llr : '0;
      bus.out_last = (state == FLUSH) &&
                     (rd_ptr == count - CNT_W'(1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nx;
   end

   // Next-state and handshake readiness.
   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         COLLECT: begin
            bus.in_ready = 1'b1;
            if (end_set) state_nx = FLUSH;
         end
         FLUSH: begin
            bus.out_valid = 1'b1;
            if (pop_last) state_nx = COLLECT;
         end
         default: state_nx = COLLECT;
      endcase
   end

   // Occupancy, flush pointer and the one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         rd_ptr   <= '0;
         dup_drop <= 1'b0;
         overflow <= 1'b0;
      end else begin
         dup_drop <= accept & hit;
         overflow <= accept & ~hit & full;
         if (do_store) count <= count + CNT_W'(1);
         if (end_set) begin
            rd_ptr <= '0;
         end else if (pop_last) begin
            rd_ptr <= '0;
            count  <= '0;
         end else if (pop) begin
            rd_ptr <= rd_ptr + CNT_W'(1);
         end
      end
   end

   // Slot storage: new uniques go to slot[count], giving arrival order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_mem[i]   <= '0;
            llr_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (do_store && count == CNT_W'(i)) begin
               q_mem[i]   <= bus.in_q;
               llr_mem[i] <= bus.in_llr;
            end
`ifdef NBLDPC_DUP_MAXLLR_EN
            if (accept && hit_vec[i] && bus.in_llr > llr_mem[i]) begin
               llr_mem[i] <= bus.in_llr;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_nbldpc_dup_buffer.sv
// Directed bench for nbldpc_dup_buffer (DEPTH=4) with a scoreboard queue.
// Honours NBLDPC_DUP_MAXLLR_EN in its reference model.
module tb_nbldpc_dup_buffer;

   localparam int Q_W   = 7;
   localparam int LLR_W = 6;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] count;
   logic             dup_drop;
   logic             overflow;

   int checks = 0;
   int errors = 0;

   logic [Q_W-1:0]   mq [$];
   logic [LLR_W-1:0] ml [$];
   logic [Q_W-1:0]   eq [$];
   logic [LLR_W-1:0] el [$];

   nbldpc_dup_buffer_if #(.Q_W(Q_W), .LLR_W(LLR_W)) bus ();

   nbldpc_dup_buffer #(
      .Q_W   (Q_W),
      .LLR_W (LLR_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .count    (count),
      .dup_drop (dup_drop),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [Q_W-1:0] q, input logic [LLR_W-1:0] llr,
                       input logic last);
      int  idx;
      bit  exp_dup;
      bit  exp_ovf;
      idx = -1;
      for (int i = 0; i < mq.size(); i++) if (mq[i] == q) idx = i;
      exp_dup = (idx >= 0);
      exp_ovf = (idx < 0) && (mq.size() == DEPTH);
      if (idx >= 0) begin
`ifdef NBLDPC_DUP_MAXLLR_EN
         if (llr > ml[idx]) ml[idx] = llr;
`endif
      end else if (!exp_ovf) begin
         mq.push_back(q);
         ml.push_back(llr);
      end
      chk("in_ready_collect", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_q     = q;
      bus.in_llr   = llr;
      bus.in_last  = last;
      @(posedge clk);
      #1;
      if (last) begin
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
      end
      chk("dup_drop", 32'(dup_drop), 32'(exp_dup));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("count", 32'(count), 32'(mq.size()));
      if (last) begin
         while (mq.size() > 0) begin
            eq.push_back(mq.pop_front());
            el.push_back(ml.pop_front());
         end
      end
   endtask

   task automatic drain(input logic [3:0] pat, input int max_pops);
      int k;
      int pops;
      logic hs;
      k    = 0;
      pops = 0;
      while (eq.size() > 0 && pops < max_pops) begin
         if (k >= 64) begin
            chk("drain_timeout", 32'(eq.size()), 32'd0);
            break;
         end
         bus.out_ready = pat[k%4];
         #1;
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk("in_ready_flush", 32'(bus.in_ready), 32'd0);
         chk("out_q", 32'(bus.out_q), 32'(eq[0]));
         chk("out_llr", 32'(bus.out_llr), 32'(el[0]));
         chk("out_last", 32'(bus.out_last), 32'(eq.size() == 1));
         hs = bus.out_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            void'(eq.pop_front());
            void'(el.pop_front());
            pops++;
         end
         k++;
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic idle_check();
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_q      = '0;
      bus.in_llr    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_out_q", 32'(bus.out_q), 32'd0);
      chk("rst_out_llr", 32'(bus.out_llr), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dup_drop", 32'(dup_drop), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Duplicate in the middle of a set.
      send(7'd3, 6'd10, 1'b0);
      send(7'd5, 6'd10, 1'b0);
      send(7'd3, 6'd10, 1'b0);
      send(7'd7, 6'd10, 1'b1);
      drain(4'b1111, 100);
      idle_check();

      // Overflow past DEPTH unique entries.
      send(7'd1, 6'd1, 1'b0);
      send(7'd2, 6'd2, 1'b0);
      send(7'd3, 6'd3, 1'b0);
      send(7'd4, 6'd4, 1'b0);
      send(7'd5, 6'd5, 1'b0);
      send(7'd6, 6'd6, 1'b1);
      drain(4'b1111, 100);
      idle_check();

      // Back-to-back identical Q.
      send(7'd9, 6'd33, 1'b0);
      send(7'd9, 6'd12, 1'b1);
      drain(4'b1111, 100);
      idle_check();

      // Duplicate with larger LLR.
      send(7'd2, 6'd4, 1'b0);
      send(7'd2, 6'd20, 1'b1);
      drain(4'b1111, 100);
      idle_check();

      // Output backpressure 1,0,0,1.
      send(7'd11, 6'd21, 1'b0);
      send(7'd12, 6'd22, 1'b0);
      send(7'd13, 6'd23, 1'b1);
      drain(4'b1001, 100);
      idle_check();

      // Reset in the middle of a flush.
      send(7'd20, 6'd1, 1'b0);
      send(7'd21, 6'd2, 1'b0);
      send(7'd22, 6'd3, 1'b1);
      drain(4'b1111, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      eq.delete();
      el.delete();
      mq.delete();
      ml.delete();
      send(7'd8, 6'd17, 1'b1);
      drain(4'b1111, 100);
      idle_check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nbldpc_dup_buffer.md
# nbldpc_dup_buffer

Parametrised duplicate-suppressing buffer for the non-binary LDPC check-node candidate path. It collects one candidate set of (Q, LLR) symbol pairs, discards every symbol whose Q value is already held, and allocates its own storage slots with an internal counter instead of an external slot mask. At end of set it streams the unique entries out over a valid/ready handshake, then clears itself for the next set.

## Interface
- Q_W, 7, symbol (GF element) width
- LLR_W, 6, reliability width, unsigned, larger = more reliable
- DEPTH, 32, maximum unique entries per set, ≥1
- CNT_W, $clog2(DEPTH+1), width of count/pointers
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat offered
- in_ready  out  1  buffer accepts input (COLLECT state)
- in_q  in  Q_W  candidate symbol
- in_llr  in  LLR_W  candidate reliability
- in_last  in  1  final beat of current set
- out_valid  out  1  unique entry presented (FLUSH state)
- out_ready  in  1  downstream accepts entry
- out_q  out  Q_W  entry symbol
- out_llr  out  LLR_W  entry reliability
- out_last  out  1  presented entry is final of set
- count  out  CNT_W  unique entries currently held
- dup_drop  out  1  one-cycle pulse: last accepted beat was a duplicate
- overflow  out  1  one-cycle pulse: last accepted beat was unique but buffer full

## Operation
- States: COLLECT, FLUSH. Reset → COLLECT.
- Accept = in_valid & in_ready. in_ready = (state==COLLECT); out_valid = (state==FLUSH).
- On accept, in_q compared in parallel against entry[0..count-1] (only occupied slots; stale contents ignored).
  - Match: beat dropped, dup_drop pulses next cycle, count unchanged.
  - No match, count<DEPTH: entry[count] ← (in_q, in_llr), count ← count+1.
  - No match, count==DEPTH: beat dropped, overflow pulses next cycle.
- Accept with in_last=1: above processing applies to that beat, then state → FLUSH, rd_ptr ← 0.
- FLUSH: out_q/out_llr = entry[rd_ptr]; out_last = (rd_ptr==count-1). On out_valid & out_ready: rd_ptr+1; if out_last, count ← 0, rd_ptr ← 0, state → COLLECT.
- Entering FLUSH with count==0 cannot occur (first beat of any set is always stored).
- Entry order on output = first-arrival order.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_q=0, out_llr=0, count=0, dup_drop=0, overflow=0; rd_ptr=0; all entries cleared.
- Throughput: one input beat per cycle in COLLECT, one output beat per cycle in FLUSH.
- Latency: stored beat visible in count and in the compare set the cycle after accept. Back-to-back identical Q on consecutive cycles must detect the second as duplicate; the write from cycle N is compared in cycle N+1.
- First out_valid: cycle after the in_last accept. in_ready low for the whole of FLUSH; first new accept possible the cycle after the final output handshake.
- out_q/out_llr/out_last stable while out_valid & !out_ready.
- dup_drop/overflow: registered, high exactly one cycle, cycle after the accept.
- rst_n asserted mid-set or mid-flush: immediate abandonment, all state to reset values; no partial output after release.

## Configuration
- NBLDPC_DUP_MAXLLR_EN defined: on a duplicate hit, if in_llr > stored llr (unsigned), stored llr ← in_llr; Q and slot order unchanged; dup_drop still pulses.
- Not defined: first occurrence kept; duplicate LLR ignored.

## Test plan
- DEPTH=4: set Q=3,5,3,7(last), LLR=10 each → dup_drop on 3rd beat; outputs (3,10),(5,10),(7,10), out_last on third; count 3→0 after flush.
- DEPTH=4: unique Q=1,2,3,4,5,6(last) → overflow pulses for 5 and 6; exactly 4 outputs 1..4.
- Back-to-back Q=9,9(last) consecutive cycles → single output (9,·), one dup_drop.
- MAXLLR_EN: Q=2/LLR=4, Q=2/LLR=20(last) → output (2,20); without macro → (2,4).
- FLUSH with out_ready toggling 1,0,0,1 → outputs held stable, in_ready=0 throughout, no loss/duplication.
- rst_n low for one cycle mid-flush → count=0, out_valid=0, next set Q=8(last) outputs only (8,·).
